// File: rtl/settings_cmd_arbiter.sv
// Round-robin arbiter that turns requester commands into one-cycle on/off/toggle pulses
// on a flag bank, keeps a shadow copy, and enforces a settle cooldown after every command.
// Define SETTINGS_CMD_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// INIT     | after reset: one all-ones turn_off pulse, then go idle
// IDLE     | pick a winner among valid requesters, latch its command
// ISSUE    | ack winner, pulse the addressed flag, update the shadow
// COOLDOWN | hold off new commands for COOLDOWN_CYCLES cycles
module settings_cmd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int NUM_SETTINGS    = 8,
    parameter int ADDR_W          = 3,
    parameter int COOLDOWN_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_SETTINGS-1:0]   turn_on,
    output logic [NUM_SETTINGS-1:0]   turn_off,
    output logic [NUM_SETTINGS-1:0]   toggle,
    output logic [NUM_SETTINGS-1:0]   settings,
    output logic                      busy,
    output logic                      cmd_err
);

    localparam int LGW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CD_LOAD = CW'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
    localparam logic [LGW-1:0] LG_RST  = LGW'(NUM_REQ - 1);

    localparam logic [1:0] OP_ON  = 2'b01;
    localparam logic [1:0] OP_OFF = 2'b10;
    localparam logic [1:0] OP_TOG = 2'b11;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_COOLDOWN} state_t;

    state_t                  state;
    logic [LGW-1:0]          last_grant;
    logic [CW-1:0]           cd_cnt;
    logic [1:0]              cmd_op;
    logic [NUM_SETTINGS-1:0] cmd_hot;
    logic                    init_pulsed;

    logic                    win_found;
    logic [LGW-1:0]          win_idx;
    logic [1:0]              win_op;
    logic [ADDR_W-1:0]       win_addr;
    logic [NUM_SETTINGS-1:0] win_hot;
    logic                    win_bad;
    int                      cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_op    = 2'b00;
        win_addr  = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SETTINGS_CMD_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(last_grant) + 1 + k) % NUM_REQ;
`endif
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = LGW'(cand);
                win_op    = req_op[2*cand +: 2];
                win_addr  = req_addr[ADDR_W*cand +: ADDR_W];
            end
        end
    end

    // An out-of-range address decodes to an all-zero mask, so it never pulses a flag.
    always_comb begin
        win_hot = '0;
        for (int s = 0; s < NUM_SETTINGS; s++) begin
            if (int'(win_addr) == s) win_hot[s] = 1'b1;
        end
        win_bad = (int'(win_addr) >= NUM_SETTINGS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT;
            last_grant  <= LG_RST;
            cd_cnt      <= '0;
            cmd_op      <= 2'b00;
            cmd_hot     <= '0;
            init_pulsed <= 1'b0;
            req_ready   <= '0;
            turn_on     <= '0;
            turn_off    <= '0;
            toggle      <= '0;
            settings    <= '0;
            busy        <= 1'b1;
            cmd_err     <= 1'b0;
        end else begin
            req_ready <= '0;
            turn_on   <= '0;
            turn_off  <= '0;
            toggle    <= '0;
            cmd_err   <= 1'b0;
            case (state)
                S_INIT: begin
                    if (!init_pulsed) begin
                        turn_off    <= '1;
                        init_pulsed <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (win_found) begin
                        state              <= S_ISSUE;
                        busy               <= 1'b1;
                        last_grant         <= win_idx;
                        cmd_op             <= win_op;
                        cmd_hot            <= win_hot;
                        req_ready[win_idx] <= 1'b1;
                        cmd_err            <= win_bad;
                        case (win_op)
                            OP_ON:   turn_on  <= win_hot;
                            OP_OFF:  turn_off <= win_hot;
                            OP_TOG:  toggle   <= win_hot;
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    case (cmd_op)
                        OP_ON:   settings <= settings | cmd_hot;
                        OP_OFF:  settings <= settings & ~cmd_hot;
                        OP_TOG:  settings <= settings ^ cmd_hot;
                        default: ;
                    endcase
                    if (COOLDOWN_CYCLES > 0) begin
                        state  <= S_COOLDOWN;
                        cd_cnt <= CD_LOAD;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cd_cnt <= cd_cnt - CW'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_settings_cmd_arbiter.sv
// Scoreboard bench for settings_cmd_arbiter: stimulus pushes expected grants, a negedge
// monitor pops and compares them. Instance a: 8 settings, instance b: 6 settings.
module tb_settings_cmd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  a_valid, b_valid;
    logic [7:0]  a_op, b_op;
    logic [11:0] a_addr, b_addr;
    logic [3:0]  a_ready, b_ready;
    logic [7:0]  a_on, a_off, a_tog, a_set;
    logic [5:0]  b_on, b_off, b_tog, b_set;
    logic        a_busy, a_err, b_busy, b_err;

    settings_cmd_arbiter #(.NUM_REQ(4), .NUM_SETTINGS(8), .ADDR_W(3), .COOLDOWN_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_op(a_op), .req_addr(a_addr),
        .req_ready(a_ready), .turn_on(a_on), .turn_off(a_off), .toggle(a_tog),
        .settings(a_set), .busy(a_busy), .cmd_err(a_err));

    settings_cmd_arbiter #(.NUM_REQ(4), .NUM_SETTINGS(6), .ADDR_W(3), .COOLDOWN_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_op(b_op), .req_addr(b_addr),
        .req_ready(b_ready), .turn_on(b_on), .turn_off(b_off), .toggle(b_tog),
        .settings(b_set), .busy(b_busy), .cmd_err(b_err));

    typedef struct {
        logic [3:0] ready;
        logic [7:0] on;
        logic [7:0] off;
        logic [7:0] tog;
        logic [7:0] set;
        logic       err;
        int         gap;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] model_a  = 8'h00;
    logic [7:0] model_b  = 8'h00;
    bit         pend_set[2];
    logic [7:0] pend_val[2];
    int         last_cyc[2];
    int         need[4];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pulses, error flag and the shadow value after the command.
    task automatic push_cmd(input int id, input int r, input logic [1:0] op, input int addr,
                            input int gap, input bit aborted);
        exp_t       e;
        int         ns;
        logic [7:0] hot;
        logic [7:0] m;
        ns  = (id == 0) ? 8 : 6;
        m   = (id == 0) ? model_a : model_b;
        hot = (addr < ns) ? 8'(1 << addr) : 8'h00;
        e.ready = 4'(1 << r);
        e.on    = (op == 2'b01) ? hot : 8'h00;
        e.off   = (op == 2'b10) ? hot : 8'h00;
        e.tog   = (op == 2'b11) ? hot : 8'h00;
        e.err   = (addr >= ns);
        case (op)
            2'b01:   m = m | hot;
            2'b10:   m = m & ~hot;
            2'b11:   m = m ^ hot;
            default: ;
        endcase
        if (aborted) m = 8'h00;
        e.set = m;
        e.gap = gap;
        if (id == 0) begin model_a = m; q_a.push_back(e); end
        else begin model_b = m; q_b.push_back(e); end
    endtask

    task automatic mon_check(input int id, input logic [3:0] rdy, input logic [7:0] on,
                             input logic [7:0] off, input logic [7:0] tog,
                             input logic [7:0] set, input logic err);
        exp_t e;
        int   qs;
        if (pend_set[id]) begin
            chk($sformatf("settings_after_cmd[%0d]", id), 32'(set), 32'(pend_val[id]));
            pend_set[id] = 1'b0;
        end
        qs = (id == 0) ? q_a.size() : q_b.size();
        if (rdy != 4'b0000) begin
            if (qs == 0) begin
                chk($sformatf("unexpected_grant[%0d]", id), 32'(rdy), 32'h0);
            end else begin
                if (id == 0) e = q_a.pop_front();
                else         e = q_b.pop_front();
                chk($sformatf("req_ready[%0d]", id), 32'(rdy), 32'(e.ready));
                chk($sformatf("turn_on[%0d]", id),   32'(on),  32'(e.on));
                chk($sformatf("turn_off[%0d]", id),  32'(off), 32'(e.off));
                chk($sformatf("toggle[%0d]", id),    32'(tog), 32'(e.tog));
                chk($sformatf("cmd_err[%0d]", id),   32'(err), 32'(e.err));
                if (e.gap != 0)
                    chk($sformatf("grant_spacing[%0d]", id), 32'(cyc - last_cyc[id]), 32'(e.gap));
                last_cyc[id] = cyc;
                pend_set[id] = 1'b1;
                pend_val[id] = e.set;
            end
        end else begin
            chk($sformatf("stray_pulse[%0d]", id), 32'({on, tog, 7'b0, err}), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        mon_check(0, a_ready, a_on, a_off, a_tog, a_set, a_err);
        mon_check(1, b_ready, {2'b00, b_on}, {2'b00, b_off}, {2'b00, b_tog}, {2'b00, b_set}, b_err);
    end

    task automatic set_req(input int id, input int r, input logic [1:0] op, input int addr);
        if (id == 0) begin
            a_op[2*r +: 2]   = op;
            a_addr[3*r +: 3] = 3'(addr);
        end else begin
            b_op[2*r +: 2]   = op;
            b_addr[3*r +: 3] = 3'(addr);
        end
    endtask

    // Holds each requester valid until it has collected need[i] acks.
    task automatic serve(input int id, input int budget);
        logic [3:0] rdy;
        int         left;
        left = 0;
        for (int i = 0; i < 4; i++) begin
            if (id == 0) a_valid[i] = (need[i] > 0);
            else         b_valid[i] = (need[i] > 0);
            left += need[i];
        end
        for (int c = 0; c < budget && left > 0; c++) begin
            @(negedge clk);
            rdy = (id == 0) ? a_ready : b_ready;
            for (int i = 0; i < 4; i++) begin
                if (rdy[i] && need[i] > 0) begin
                    need[i]--;
                    left--;
                    if (need[i] == 0) begin
                        if (id == 0) a_valid[i] = 1'b0;
                        else         b_valid[i] = 1'b0;
                    end
                end
            end
        end
        if (left != 0) chk("serve_timeout_acks_left", 32'(left), 32'h0);
    endtask

    task automatic wait_idle(input int id);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 40 && !idle; c++) begin
            @(negedge clk);
            idle = (id == 0) ? !a_busy : !b_busy;
        end
        if (!idle) chk("wait_idle_timeout", 32'h1, 32'h0);
    endtask

    // Called at a negedge; rst is sampled high by the next three rising edges.
    task automatic do_reset(input bit check);
        rst = 1'b1;
        model_a = 8'h00;
        model_b = 8'h00;
        repeat (3) begin
            @(negedge clk);
            if (check) begin
                chk("rst_busy", 32'(a_busy), 32'h1);
                chk("rst_settings", 32'(a_set), 32'h0);
                chk("rst_ready", 32'(a_ready), 32'h0);
                chk("rst_pulses", 32'({a_on, a_off, a_tog}), 32'h0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("init_turn_off_a", 32'(a_off), 32'hFF);
            chk("init_turn_off_b", 32'(b_off), 32'h3F);
            chk("init_busy", 32'(a_busy), 32'h1);
            chk("init_settings", 32'(a_set), 32'h0);
        end
        @(negedge clk);
        if (check) begin
            chk("post_init_turn_off", 32'(a_off), 32'h0);
            chk("post_init_busy", 32'(a_busy), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  order[6];
    bit  seen;

    initial begin
        a_valid = '0; b_valid = '0;
        a_op = '0; b_op = '0; a_addr = '0; b_addr = '0;
        @(negedge clk);
        do_reset(1'b1);

        // Single ON: req 0, addr 5
        set_req(0, 0, 2'b01, 5);
        push_cmd(0, 0, 2'b01, 5, 0, 1'b0);
        a_valid[0] = 1'b1;
        @(negedge clk);
        chk("single_ready_latency", 32'(a_ready), 32'h1);
        chk("single_busy_issue", 32'(a_busy), 32'h1);
        a_valid[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("single_busy_cooldown", 32'(a_busy), 32'h1);
            chk("single_on_one_cycle", 32'(a_on), 32'h0);
        end
        chk("single_settings", 32'(a_set), 32'h20);
        @(negedge clk);
        chk("single_busy_drop", 32'(a_busy), 32'h0);

        // Contention: all four toggle their own bit, each drops after its ack
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            set_req(0, i, 2'b11, i);
            push_cmd(0, i, 2'b11, i, (i == 0) ? 0 : 6, 1'b0);
            need[i] = 1;
        end
        serve(0, 60);
        wait_idle(0);
        chk("contention_settings", 32'(a_set), 32'h0F);

        // Req 0 stays valid for three acks while 1..3 are pending
        do_reset(1'b0);
        set_req(0, 0, 2'b11, 4);
        for (int i = 1; i < 4; i++) set_req(0, i, 2'b11, i);
`ifdef SETTINGS_CMD_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 1, 2, 3};
`else
        order = '{0, 1, 2, 3, 0, 0};
`endif
        for (int k = 0; k < 6; k++)
            push_cmd(0, order[k], 2'b11, (order[k] == 0) ? 4 : order[k], (k == 0) ? 0 : 6, 1'b0);
        need = '{3, 1, 1, 1};
        serve(0, 80);
        wait_idle(0);
        chk("prio_settings", 32'(a_set), 32'h1E);

        // Reset during ISSUE aborts, then the pointer restarts from requester 0
        do_reset(1'b0);
        set_req(0, 1, 2'b01, 2);
        set_req(0, 3, 2'b01, 6);
        push_cmd(0, 1, 2'b01, 2, 0, 1'b1);
        a_valid = 4'b1010;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = a_ready[1];
        end
        if (!seen) chk("midop_grant_timeout", 32'h1, 32'h0);
        do_reset(1'b1);
        push_cmd(0, 1, 2'b01, 2, 0, 1'b0);
        push_cmd(0, 3, 2'b01, 6, 6, 1'b0);
        need = '{0, 1, 0, 1};
        serve(0, 60);
        wait_idle(0);
        chk("midop_settings", 32'(a_set), 32'h44);

        // Six-setting instance: valid top address, two bad addresses, then a toggle
        do_reset(1'b0);
        set_req(1, 0, 2'b01, 5);
        set_req(1, 1, 2'b00, 6);
        set_req(1, 2, 2'b01, 7);
        set_req(1, 3, 2'b11, 0);
        push_cmd(1, 0, 2'b01, 5, 0, 1'b0);
        push_cmd(1, 1, 2'b00, 6, 6, 1'b0);
        push_cmd(1, 2, 2'b01, 7, 6, 1'b0);
        push_cmd(1, 3, 2'b11, 0, 6, 1'b0);
        need = '{1, 1, 1, 1};
        serve(1, 60);
        wait_idle(1);
        chk("badaddr_settings", 32'(b_set), 32'h21);

        repeat (2) @(negedge clk);
        chk("queue_a_drained", 32'(q_a.size()), 32'h0);
        chk("queue_b_drained", 32'(q_b.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/settings_cmd_arbiter.md
Name: settings_cmd_arbiter

Overview:
- Shares the bank of single-bit system settings (on/off/toggle flags) between several command sources, e.g. the host command decoder and the trigger logic.
- Arbitrates round-robin and issues exactly one setting command per grant as one-cycle turn-on, turn-off or toggle pulses to the flag bank.
- Enforces a settle cooldown after every change and keeps a shadow copy of all setting values for readback.
- After reset, forces every downstream flag off so the flags and the shadow agree.

Parameters:
- NUM_REQ, 4, number of requesters.
- NUM_SETTINGS, 8, number of setting flags driven.
- ADDR_W, 3, setting address width; must satisfy 2^ADDR_W >= NUM_SETTINGS.
- COOLDOWN_CYCLES, 4, idle cycles after each issued command. 0 means no cooldown. Counter width is $clog2(COOLDOWN_CYCLES+1), minimum 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_op  in  2*NUM_REQ  per-requester op, slice [2i+1:2i]. Encoding: 00 NOP, 01 ON, 10 OFF, 11 TOGGLE.
- req_addr  in  ADDR_W*NUM_REQ  per-requester setting index, slice [ADDR_W*i +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot acknowledge; the command transfers when ready is high.
- turn_on  out  NUM_SETTINGS  one-cycle set pulses.
- turn_off  out  NUM_SETTINGS  one-cycle clear pulses.
- toggle  out  NUM_SETTINGS  one-cycle invert pulses.
- settings  out  NUM_SETTINGS  shadow value of each flag.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  one-cycle pulse when an accepted command has an out-of-range address.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high:
  - all pulse outputs, req_ready and cmd_err are 0; settings is 0; busy is 1.
  - state is INIT; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-command (any state) aborts the command: no ack, no pulse. rst has priority over everything.
- INIT (first cycle with rst low):
  - turn_off = all ones for exactly 1 cycle; settings stays 0.
  - next state: IDLE. Requests are ignored during INIT.
- IDLE:
  - busy = 0.
  - If any req_valid is high, select the winner w: the first valid requester searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Latch op and addr of w, set last_grant = w, go to ISSUE. No outputs change in this cycle.
- ISSUE (exactly 1 cycle; arrival at T+1 if the request was seen in IDLE at T):
  - req_ready[w] = 1. Only one ready bit is high in any cycle.
  - If addr < NUM_SETTINGS: drive the pulse for op on bit addr (ON to turn_on, OFF to turn_off, TOGGLE to toggle; NOP drives nothing).
  - If addr >= NUM_SETTINGS: no pulse, cmd_err = 1. NOP with a bad addr also raises cmd_err.
  - settings updates at the end of ISSUE (visible at T+2): ON sets, OFF clears, TOGGLE inverts, NOP holds.
  - Next state: COOLDOWN if COOLDOWN_CYCLES > 0, otherwise IDLE.
- COOLDOWN:
  - Stays exactly COOLDOWN_CYCLES cycles, then IDLE.
  - Requests wait; req_ready stays 0.
  - An error or NOP command still incurs the cooldown.
- Handshake rules:
  - A requester holds req_valid, req_op and req_addr stable until it sees req_ready.
  - Dropping valid before ready is a protocol violation; the latched command still issues.
  - A requester with valid still high after its ack is re-arbitrated as a new command.
- Throughput: one command per 2+COOLDOWN_CYCLES cycles.
- Fairness: no requester waits more than NUM_REQ-1 grants while continuously valid.
- Simultaneous requests: resolved by the round-robin rule only; op type carries no priority.

Optional Feature:
- Macro: SETTINGS_CMD_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. last_grant still updates but does not affect selection; the fairness guarantee does not apply.
- When undefined: round-robin as specified above.

Test Plan:
- Reset release: rst high 3 cycles, then low → turn_off = 8'hFF for exactly 1 cycle, settings = 0, busy falls 2 cycles after rst falls.
- Single ON: req 0, op 01, addr 5, presented in IDLE at T → req_ready[0] and turn_on[5] high at T+1 only, settings = 8'h20 at T+2, busy high T+1..T+5 (COOLDOWN_CYCLES=4).
- Contention: reqs 0–3 all valid with TOGGLE to addr 0,1,2,3, held until acked → grants in order 0,1,2,3, 6 cycles apart, final settings = 8'h0F. Repeat with the macro defined and req 0 re-asserting after each ack → req 0 wins every time.
- Bad address (NUM_SETTINGS=6): req 2, op ON, addr 7 → req_ready[2] and cmd_err pulse, no turn_on, settings unchanged, cooldown still occurs.
- Reset mid-op: assert rst during ISSUE → no pulses in the following cycle, settings = 0; after release, INIT all-off pulse occurs and the pending request is re-served starting from requester 0.
